// File: rtl/ni_route_lut_pkg.sv
// rtl/ni_route_lut_pkg.sv - shared config encodings and table entry type for the route LUT
package ni_route_pkg;

    localparam int NI_ADDR_W = 32;
    localparam int NI_PATH_W = 7;
    localparam int NI_TGT_W  = 4;

    localparam logic [1:0] CFG_BASE  = 2'd0;
    localparam logic [1:0] CFG_LIMIT = 2'd1;
    localparam logic [1:0] CFG_ROUTE = 2'd2;
    localparam logic [1:0] CFG_VALID = 2'd3;

    typedef struct packed {
        logic                 valid;
        logic [NI_ADDR_W-1:0] base;
        logic [NI_ADDR_W-1:0] limit;
        logic [NI_PATH_W-1:0] path;
        logic [NI_TGT_W-1:0]  target;
    } route_entry_t;

endpackage

// File: rtl/ni_route_lut_if.sv
// rtl/ni_route_lut_if.sv - lookup request/response handshake between initiator and route LUT
interface ni_route_if #(
    parameter int ADDR_W = 32,
    parameter int PATH_W = 7,
    parameter int TGT_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [PATH_W-1:0] resp_path;
    logic [TGT_W-1:0]  resp_target;
    logic              resp_fail;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_path, resp_target, resp_fail
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_path, resp_target, resp_fail
    );
endinterface

// File: rtl/ni_route_lut_range_cmp.sv
// rtl/ni_route_lut_range_cmp.sv - combinational window match for one table entry
module ni_route_range_cmp
    import ni_route_pkg::*;
(
    input  route_entry_t         i_entry,
    input  logic [NI_ADDR_W-1:0] i_addr,
    output logic                 o_hit,
    output logic [NI_PATH_W-1:0] o_path,
    output logic [NI_TGT_W-1:0]  o_target
);
    // base >= limit can never satisfy both bounds, so no separate empty-window test
    assign o_hit    = i_entry.valid && (i_addr >= i_entry.base) && (i_addr < i_entry.limit);
    assign o_path   = o_hit ? i_entry.path   : '0;
    assign o_target = o_hit ? i_entry.target : '0;
endmodule

// File: rtl/ni_route_lut.sv
// rtl/ni_route_lut.sv - programmable address-window route table with registered lookup
// Optional overlap detection output multi_hit under NI_ROUTE_LUT_OVERLAP_CHK_EN.
module ni_route_lut
    import ni_route_pkg::*;
#(
    parameter int                ADDR_W    = NI_ADDR_W,
    parameter int                PATH_W    = NI_PATH_W,
    parameter int                TGT_W     = NI_TGT_W,
    parameter int                N_RANGES  = 4,
    parameter int                CNT_W     = 16,
    parameter logic [ADDR_W-1:0] DEF_BASE  = 32'h1a000000,
    parameter logic [ADDR_W-1:0] DEF_LIMIT = 32'h1fffffff,
    parameter logic [PATH_W-1:0] DEF_PATH  = 7'b0000001,
    parameter logic [TGT_W-1:0]  DEF_TGT   = 4'hc,
    localparam int               IDX_W     = (N_RANGES > 1) ? $clog2(N_RANGES) : 1
) (
    input  logic              clock,
    input  logic              reset,
    ni_route_if.slave         bus,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [1:0]        cfg_field,
    input  logic [ADDR_W-1:0] cfg_wdata,
    output logic [CNT_W-1:0]  fail_cnt,
    input  logic              fail_clr
`ifdef NI_ROUTE_LUT_OVERLAP_CHK_EN
    ,
    output logic              multi_hit
`endif
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    route_entry_t       r_tab [N_RANGES];
    logic               r_resp_valid;
    logic [PATH_W-1:0]  r_resp_path;
    logic [TGT_W-1:0]   r_resp_target;
    logic               r_resp_fail;
    logic [CNT_W-1:0]   r_fail_cnt;

    logic [N_RANGES-1:0] w_hit;
    logic [PATH_W-1:0]   w_rt_path [N_RANGES];
    logic [TGT_W-1:0]    w_rt_tgt  [N_RANGES];
    logic [PATH_W-1:0]   w_path;
    logic [TGT_W-1:0]    w_tgt;
    logic                w_any;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_idx_ok;

    for (genvar g = 0; g < N_RANGES; g++) begin : g_cmp
        ni_route_range_cmp u_cmp (
            .i_entry  (r_tab[g]),
            .i_addr   (bus.req_addr),
            .o_hit    (w_hit[g]),
            .o_path   (w_rt_path[g]),
            .o_target (w_rt_tgt[g])
        );
    end

    // Walk from the top so the lowest matching index is the last to be written
    always_comb begin
        w_path = '0;
        w_tgt  = '0;
        w_any  = 1'b0;
        for (int i = N_RANGES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_path = w_rt_path[i];
                w_tgt  = w_rt_tgt[i];
                w_any  = 1'b1;
            end
        end
    end

    assign w_req_ready = !r_resp_valid || bus.resp_ready;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_idx_ok    = ({{(32-IDX_W){1'b0}}, cfg_idx} < 32'(N_RANGES));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_RANGES; i++) begin
                r_tab[i] <= '0;
            end
            r_tab[0] <= '{valid: 1'b1, base: DEF_BASE, limit: DEF_LIMIT,
                          path: DEF_PATH, target: DEF_TGT};
        end else if (cfg_we && w_idx_ok) begin
            case (cfg_field)
                CFG_BASE:  r_tab[cfg_idx].base  <= cfg_wdata;
                CFG_LIMIT: r_tab[cfg_idx].limit <= cfg_wdata;
                CFG_ROUTE: begin
                    r_tab[cfg_idx].path   <= cfg_wdata[PATH_W-1:0];
                    r_tab[cfg_idx].target <= cfg_wdata[PATH_W+TGT_W-1:PATH_W];
                end
                CFG_VALID: r_tab[cfg_idx].valid <= cfg_wdata[0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_resp_valid  <= 1'b0;
            r_resp_path   <= '0;
            r_resp_target <= '0;
            r_resp_fail   <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid  <= 1'b1;
            r_resp_path   <= w_path;
            r_resp_target <= w_tgt;
            r_resp_fail   <= !w_any;
        end else if (bus.resp_ready) begin
            r_resp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || fail_clr) begin
            r_fail_cnt <= '0;
        end else if (w_accept && !w_any && (r_fail_cnt != CNT_MAX)) begin
            r_fail_cnt <= r_fail_cnt + CNT_ONE;
        end
    end

`ifdef NI_ROUTE_LUT_OVERLAP_CHK_EN
    logic r_multi_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_multi_hit <= 1'b0;
        end else if (w_accept) begin
            r_multi_hit <= ($countones(w_hit) > 1);
        end
    end

    assign multi_hit = r_multi_hit;
`endif

    assign bus.req_ready   = w_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_path   = r_resp_path;
    assign bus.resp_target = r_resp_target;
    assign bus.resp_fail   = r_resp_fail;
    assign fail_cnt        = r_fail_cnt;
endmodule

// File: tb/tb_ni_route_lut.sv
// tb/tb_ni_route_lut.sv - scoreboard and vector-table bench for ni_route_lut
module tb_ni_route_lut;
    import ni_route_pkg::*;

    typedef struct {
        logic [6:0] path;
        logic [3:0] tgt;
        logic       fail;
        logic       multi;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [6:0]  path;
        logic [3:0]  tgt;
        logic        fail;
        logic        multi;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [1:0]  cfg_field = '0;
    logic [31:0] cfg_wdata = '0;
    logic [15:0] fail_cnt;
    logic        fail_clr = 1'b0;
`ifdef NI_ROUTE_LUT_OVERLAP_CHK_EN
    logic        multi_hit;
`endif

    int   total = 0;
    int   bad = 0;
    int   stall_cnt = 0;
    bit   sb_on = 1'b1;
    exp_t sb[$];

    ni_route_if bus ();

    ni_route_lut dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_field (cfg_field),
        .cfg_wdata (cfg_wdata),
        .fail_cnt  (fail_cnt),
        .fail_clr  (fail_clr)
`ifdef NI_ROUTE_LUT_OVERLAP_CHK_EN
        ,
        .multi_hit (multi_hit)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (sb_on && !reset && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_path", 32'(bus.resp_path), 32'(e.path));
                chk("resp_target", 32'(bus.resp_target), 32'(e.tgt));
                chk("resp_fail", 32'(bus.resp_fail), 32'(e.fail));
`ifdef NI_ROUTE_LUT_OVERLAP_CHK_EN
                chk("multi_hit", 32'(multi_hit), 32'(e.multi));
`endif
            end
        end
    end

    // Called right after a rising edge; returns right after the accepting edge
    task automatic send(input logic [31:0] a, input logic [6:0] p, input logic [3:0] t,
                        input logic f, input logic m);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(negedge clock);
        while (!bus.req_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        stall_cnt += n;
        if (!bus.req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        else sb.push_back('{path: p, tgt: t, fail: f, multi: m});
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic cfg_wr(input logic [1:0] idx, input logic [1:0] fld, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_field = fld;
        cfg_wdata = d;
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clock);
        #1;
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        int   n_fail;

        vt[0]  = '{32'h1a000000, 7'h01, 4'hc, 1'b0, 1'b1};
        vt[1]  = '{32'h1fffffff, 7'h00, 4'h0, 1'b1, 1'b0};
        vt[2]  = '{32'h1ffffffe, 7'h01, 4'hc, 1'b0, 1'b0};
        vt[3]  = '{32'h19ffffff, 7'h00, 4'h0, 1'b1, 1'b0};
        vt[4]  = '{32'h10000ffc, 7'h06, 4'h3, 1'b0, 1'b0};
        vt[5]  = '{32'h10001000, 7'h00, 4'h0, 1'b1, 1'b0};
        vt[6]  = '{32'h10000000, 7'h06, 4'h3, 1'b0, 1'b0};
        vt[7]  = '{32'h1a00ffff, 7'h01, 4'hc, 1'b0, 1'b1};
        vt[8]  = '{32'h1a010000, 7'h01, 4'hc, 1'b0, 1'b0};
        vt[9]  = '{32'h30000000, 7'h00, 4'h0, 1'b1, 1'b0};
        vt[10] = '{32'h00000000, 7'h00, 4'h0, 1'b1, 1'b0};
        vt[11] = '{32'hffffffff, 7'h00, 4'h0, 1'b1, 1'b0};

        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_path", 32'(bus.resp_path), 32'd0);
        chk("rst_resp_target", 32'(bus.resp_target), 32'd0);
        chk("rst_resp_fail", 32'(bus.resp_fail), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        #1;

        cfg_wr(2'd1, CFG_BASE,  32'h10000000);
        cfg_wr(2'd1, CFG_LIMIT, 32'h10001000);
        cfg_wr(2'd1, CFG_ROUTE, {21'd0, 4'h3, 7'b0000110});
        cfg_wr(2'd1, CFG_VALID, 32'd1);
        cfg_wr(2'd2, CFG_BASE,  32'h1a000000);
        cfg_wr(2'd2, CFG_LIMIT, 32'h1a010000);
        cfg_wr(2'd2, CFG_ROUTE, {21'd0, 4'h5, 7'b0101010});
        cfg_wr(2'd2, CFG_VALID, 32'd1);
        cfg_wr(2'd3, CFG_BASE,  32'h30000000);
        cfg_wr(2'd3, CFG_LIMIT, 32'h30000000);
        cfg_wr(2'd3, CFG_VALID, 32'd1);

        n_fail = 0;
        stall_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            send(vt[i].addr, vt[i].path, vt[i].tgt, vt[i].fail, vt[i].multi);
            if (vt[i].fail) n_fail++;
        end
        drain("table_drain");
        chk("table_stalls", 32'(stall_cnt), 32'd0);
        chk("table_fail_cnt", 32'(fail_cnt), 32'(n_fail));

        // Backpressure: one response parked, second request must wait
        bus.resp_ready = 1'b0;
        send(32'h1b000000, 7'h01, 4'hc, 1'b0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h10000000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_resp_path", 32'(bus.resp_path), 32'h01);
            chk("bp_resp_target", 32'(bus.resp_target), 32'hc);
            chk("bp_resp_fail", 32'(bus.resp_fail), 32'd0);
        end
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
        sb.push_back('{path: 7'h06, tgt: 4'h3, fail: 1'b0, multi: 1'b0});
        @(posedge clock);
        #1;
        stall_cnt = 0;
        send(32'h1a010000, 7'h01, 4'hc, 1'b0, 1'b0);
        send(32'h10000ffc, 7'h06, 4'h3, 1'b0, 1'b0);
        chk("stream_stalls", 32'(stall_cnt), 32'd0);
        drain("bp_drain");

        // Invalidate entry 0 in the same cycle a lookup is accepted
        cfg_we    = 1'b1;
        cfg_idx   = 2'd0;
        cfg_field = CFG_VALID;
        cfg_wdata = 32'd0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h1b000000;
        @(negedge clock);
        chk("same_cycle_ready", 32'(bus.req_ready), 32'd1);
        sb.push_back('{path: 7'h01, tgt: 4'hc, fail: 1'b0, multi: 1'b0});
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
        bus.req_valid = 1'b0;
        send(32'h1b000000, 7'h00, 4'h0, 1'b1, 1'b0);
        drain("same_cycle_drain");

        // Saturation of the failure counter
        sb_on = 1'b0;
        fail_clr = 1'b1;
        @(posedge clock);
        #1;
        fail_clr = 1'b0;
        @(negedge clock);
        chk("clr_fail_cnt", 32'(fail_cnt), 32'd0);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h00000000;
        repeat ((1 << 16) + 3) @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("sat_fail_cnt", 32'(fail_cnt), 32'h0000ffff);
        @(posedge clock);
        #1;
        fail_clr = 1'b1;
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1;
        fail_clr = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("clr_prio_fail_cnt", 32'(fail_cnt), 32'd0);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("post_clr_fail_cnt", 32'(fail_cnt), 32'd1);
        repeat (2) @(posedge clock);
        #1;
        sb_on = 1'b1;

        // Reset with a parked response and entry 1 programmed
        bus.resp_ready = 1'b0;
        send(32'h10000000, 7'h06, 4'h3, 1'b0, 1'b0);
        @(negedge clock);
        chk("pre_rst_resp_valid", 32'(bus.resp_valid), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clock);
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("mid_rst_resp_path", 32'(bus.resp_path), 32'd0);
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b1;
        send(32'h10000ffc, 7'h00, 4'h0, 1'b1, 1'b0);
        send(32'h1b000000, 7'h01, 4'hc, 1'b0, 1'b0);
        drain("rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ni_route_lut.md
Name: ni_route_lut

Overview:
- Parametrised, run-time programmable successor of the per-initiator routing table in the NI initiator.
- Holds N_RANGES address windows, each with its own source route (path) and target ID.
- Performs a registered lookup behind a valid/ready handshake toward the NI packetiser.
- Counts decoding failures.

Parameters:
ADDR_W, 32, address width
PATH_W, 7, route width; first hop in LSBs, last hop in MSBs
TGT_W, 4, transaction target ID width
N_RANGES, 4, number of table entries (1..16)
CNT_W, 16, failure counter width
DEF_BASE, 32'h1a000000, entry 0 base after reset
DEF_LIMIT, 32'h1fffffff, entry 0 limit after reset (exclusive)
DEF_PATH, 7'b0000001, entry 0 path after reset
DEF_TGT, 4'hc, entry 0 target after reset

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  lookup request valid
req_ready  out  1  lookup request accepted when high with req_valid
req_addr  in  ADDR_W  address to decode
resp_valid  out  1  lookup result valid
resp_ready  in  1  consumer accepts result
resp_path  out  PATH_W  route of matching entry; 0 on failure
resp_target  out  TGT_W  target of matching entry; 0 on failure
resp_fail  out  1  no entry matched
cfg_we  in  1  table write strobe
cfg_idx  in  $clog2(N_RANGES) (min 1)  entry index
cfg_field  in  2  0=base, 1=limit, 2={target,path} in LSBs, 3=valid bit (wdata[0])
cfg_wdata  in  ADDR_W  write data
fail_cnt  out  CNT_W  saturating count of failed lookups
fail_clr  in  1  clear fail_cnt

Behaviour:
- Reset applies only on a rising clock edge with reset=1.
  - Entry 0 is loaded from the DEF_* parameters with valid=1.
  - Entries 1..N-1 are cleared to zero with valid=0.
  - resp_valid=0, resp_path=0, resp_target=0, resp_fail=0, fail_cnt=0.
- Match rule for entry i: valid_i && base_i <= addr < limit_i (unsigned). An entry with base >= limit never matches.
- Priority: the lowest-index matching entry wins.
- Handshake:
  - req_ready = !resp_valid || resp_ready, combinational from output state and resp_ready only (never from req_valid).
  - On accept (req_valid && req_ready), the lookup result is registered and resp_valid=1 the next cycle. Latency is 1 cycle.
  - Back-to-back accepts at full throughput are allowed.
  - While resp_valid && !resp_ready, all resp_* outputs hold stable.
  - A response clears (resp_valid=0) when consumed with no new accept in the same cycle.
- Failure:
  - resp_fail=1 with path=0 and target=0.
  - fail_cnt increments once per accepted failing request and saturates at all-ones.
  - fail_clr has priority over an increment in the same cycle; the counter then reads 0.
- Config:
  - A write takes effect at the clock edge.
  - A lookup accepted in the same cycle uses the pre-write table.
  - cfg_idx >= N_RANGES: the write is ignored.
  - Field 2 writes target into cfg_wdata[PATH_W+TGT_W-1:PATH_W] and path into cfg_wdata[PATH_W-1:0].
- Reset mid-operation discards any pending response and restores the default table. req_ready is 1 in the first cycle after reset.

Optional Feature:
- Macro: NI_ROUTE_LUT_OVERLAP_CHK_EN.
- Defined: adds output port multi_hit (1 bit). It is registered alongside the response and is 1 when two or more valid entries match the accepted address. The result still follows lowest-index priority, and fail_cnt is unaffected.
- Undefined: the port and the logic are absent.

Decomposition:
- Package ni_route_pkg holds:
  - cfg_field encodings as localparams: CFG_BASE=0, CFG_LIMIT=1, CFG_ROUTE=2, CFG_VALID=3.
  - The entry struct {valid, base, limit, path, target}.
- Sub-module ni_route_range_cmp is instantiated per entry. It is combinational: entry plus address in, hit out. The priority encoder and registers stay in the top module.

Test Plan:
- Reset, then req_addr=0x1a000000 -> next cycle resp_valid=1, path=7'b0000001, target=4'hc, fail=0. req_addr=0x1fffffff -> fail=1, path=0, fail_cnt=1 (exclusive limit).
- Program entry 1 (base 0x10000000, limit 0x10001000, route target=3, path=7'b0000110, valid). Then lookup 0x10000ffc -> path=7'b0000110, target=3. Lookup 0x10001000 -> fail.
- Hold resp_ready=0 with a response pending -> req_ready=0, outputs stable for 5 cycles. Then release -> the queued request is accepted and streams 1 per cycle.
- Same cycle: cfg write invalidating entry 0 plus a lookup of 0x1b000000 -> that response hits. The next lookup of 0x1b000000 fails.
- Force 2^CNT_W+3 failures -> fail_cnt saturates at all-ones. Assert fail_clr together with a failing accept -> fail_cnt=0.
- Assert reset while resp_valid=1 and entry 1 programmed -> next cycle resp_valid=0, entry 1 invalid, entry 0 back to default.
